// File: rtl/prescaled_digit_counter.sv
`default_nettype none
// ============================================================================
// Module      : prescaled_digit_counter
// Description : Prescaled single-digit up/down counter with run/hold,
//               synchronous clear, clamped parallel load, 4-step speed select,
//               hex 7-segment decode, heartbeat decimal point and tick/wrap
//               strobes for chaining.
// Revision    : 1.0 - initial release
// ============================================================================
module prescaled_digit_counter #(
    parameter int PRESCALE     = 10_000_000,
    parameter int CNT_WIDTH    = 24,
    parameter int DIGIT_MAX    = 9,
    parameter bit COMMON_ANODE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       run,
    input  logic       up_dn,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic [1:0] speed,
    output logic [3:0] digit,
    output logic [6:0] segments,
    output logic       dp,
    output logic       tick,
    output logic       wrap,
    output logic [7:0] pre_cnt
);

    localparam logic [CNT_WIDTH-1:0] c_PRESCALE  = CNT_WIDTH'(PRESCALE);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [3:0]           c_DIGIT_MAX = 4'(DIGIT_MAX);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic [CNT_WIDTH-1:0] w_limit;
    logic [CNT_WIDTH-1:0] w_limit_m1;
    logic [3:0]           r_digit;
    logic [3:0]           w_digit_next;
    logic [3:0]           w_load_clamped;
    logic                 r_dp;
    logic                 w_dp_next;
    logic                 w_tick;
    logic                 w_wrap;
    logic                 w_tick_due;
    logic [6:0]           w_seg_raw;

    // Step period shrinks by powers of two with speed; PRESCALE >= 8 keeps
    // the limit at least 1 for every speed setting.
    assign w_limit    = c_PRESCALE >> speed;
    assign w_limit_m1 = w_limit - c_CNT_ONE;

    // Greater-or-equal so a mid-count switch to a faster speed ticks on the
    // next active cycle instead of running the counter all the way round.
    assign w_tick_due = run && (r_cnt >= w_limit_m1);

    assign w_load_clamped = (load_val > c_DIGIT_MAX) ? c_DIGIT_MAX : load_val;

    // Next-state and strobes: reset > clear > load > tick step > count
    always_comb begin
        w_cnt_next   = r_cnt;
        w_digit_next = r_digit;
        w_dp_next    = r_dp;
        w_tick       = 1'b0;
        w_wrap       = 1'b0;
        if (!rst_n || clear) begin
            w_cnt_next   = '0;
            w_digit_next = 4'd0;
            w_dp_next    = 1'b0;
        end else if (load) begin
            // A load swallows any tick due this cycle and restarts the period
            w_digit_next = w_load_clamped;
            w_cnt_next   = '0;
        end else if (w_tick_due) begin
            w_tick     = 1'b1;
            w_cnt_next = '0;
            w_dp_next  = ~r_dp;
            if (up_dn) begin
                if (r_digit == c_DIGIT_MAX) begin
                    w_digit_next = 4'd0;
                    w_wrap       = 1'b1;
                end else begin
                    w_digit_next = r_digit + 4'd1;
                end
            end else begin
                if (r_digit == 4'd0) begin
                    w_digit_next = c_DIGIT_MAX;
                    w_wrap       = 1'b1;
                end else begin
                    w_digit_next = r_digit - 4'd1;
                end
            end
        end else if (run) begin
            w_cnt_next = r_cnt + c_CNT_ONE;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_digit <= 4'd0;
            r_dp    <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_digit <= w_digit_next;
            r_dp    <= w_dp_next;
        end
    end

    // Hex 7-segment decode, {g,f,e,d,c,b,a}, active-high before polarity
    always_comb begin
        w_seg_raw = 7'b0000000;
        case (r_digit)
            4'h0: w_seg_raw = 7'b0111111;
            4'h1: w_seg_raw = 7'b0000110;
            4'h2: w_seg_raw = 7'b1011011;
            4'h3: w_seg_raw = 7'b1001111;
            4'h4: w_seg_raw = 7'b1100110;
            4'h5: w_seg_raw = 7'b1101101;
            4'h6: w_seg_raw = 7'b1111101;
            4'h7: w_seg_raw = 7'b0000111;
            4'h8: w_seg_raw = 7'b1111111;
            4'h9: w_seg_raw = 7'b1101111;
            4'hA: w_seg_raw = 7'b1110111;
            4'hB: w_seg_raw = 7'b1111100;
            4'hC: w_seg_raw = 7'b0111001;
            4'hD: w_seg_raw = 7'b1011110;
            4'hE: w_seg_raw = 7'b1111001;
            4'hF: w_seg_raw = 7'b1110001;
            default: w_seg_raw = 7'b0000000;
        endcase
    end

    assign digit    = r_digit;
    assign segments = w_seg_raw ^ {7{COMMON_ANODE}};
    assign dp       = r_dp ^ COMMON_ANODE;
    assign tick     = w_tick;
    assign wrap     = w_wrap;
    // Truncates wide counters, zero-fills narrow ones
    assign pre_cnt  = 8'(r_cnt);

endmodule
`default_nettype wire

// File: doc/prescaled_digit_counter.md
# prescaled_digit_counter

Parametrised prescaled single-digit counter with direct 7-segment drive, the standard display front end for our one-digit demo tiles. A prescaler divides the system clock to a step tick. The digit counts up or down modulo a configurable maximum, with run/hold, synchronous clear, parallel load and a 4-step speed select. Outputs are a hex-capable 7-segment pattern, a heartbeat decimal point, and tick/wrap strobes for chaining.

## Interface
- PRESCALE, 10_000_000: clock cycles per step at speed 0; legal range 8 ≤ PRESCALE < 2^CNT_WIDTH
- CNT_WIDTH, 24: prescaler register width
- DIGIT_MAX, 9: highest digit value before wrap; legal range 1..15
- COMMON_ANODE, 0: 1 inverts `segments` and `dp` (active-low drive)
- clk  in  1  the single clock
- rst_n  in  1  reset; synchronous, active-low
- clear  in  1  synchronous clear of prescaler and digit
- run  in  1  1 = prescaler advances; 0 = hold
- up_dn  in  1  1 = count up, 0 = count down
- load  in  1  load `load_val` into digit
- load_val  in  4  value to load
- speed  in  2  step period = PRESCALE >> speed cycles
- digit  out  4  current digit, registered
- segments  out  7  {g,f,e,d,c,b,a}; bit 0 = a
- dp  out  1  heartbeat; toggles every tick
- tick  out  1  one-cycle step strobe
- wrap  out  1  one-cycle strobe when the digit wraps
- pre_cnt  out  8  prescaler bits [7:0], for debug

## Operation
- limit = PRESCALE >> speed, computed at CNT_WIDTH bits.
- Prescaler `cnt`:
  - While run=1, the cycle where cnt ≥ limit−1 is a tick cycle and cnt ← 0 on that cycle.
  - Otherwise cnt ← cnt+1.
  - Step period is exactly `limit` cycles.
  - The ≥ compare covers a speed change mid-count: if cnt already exceeds the new limit−1, the next active cycle ticks.
- run=0: cnt, digit and dp hold; tick=0; wrap=0.
- Priority, highest first: rst_n=0 > clear > load > tick step.
- Reset or clear: cnt←0, digit←0, dp←0. tick and wrap are 0 that cycle.
- Load:
  - digit ← min(load_val, DIGIT_MAX), and cnt←0.
  - A tick that would occur in the same cycle is suppressed: tick=0 and no step.
  - dp holds.
- Tick step, up_dn=1: digit==DIGIT_MAX → 0 with wrap=1; otherwise digit+1.
- Tick step, up_dn=0: digit==0 → DIGIT_MAX with wrap=1; otherwise digit−1.
- Every tick toggles dp.
- up_dn may change on any cycle. It is sampled only on tick cycles.
- Segment decode, combinational from the `digit` register, {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- COMMON_ANODE=1 inverts both segments and dp at the output.
- pre_cnt = cnt[7:0]. Upper bits zero-fill when CNT_WIDTH < 8.

## Timing
- All state updates on posedge clk. No asynchronous paths.
- digit, dp and cnt are registered.
- tick and wrap are combinational from registered state and inputs in the cycle where the step is committed. The new digit is visible the following cycle.
- segments follow digit with zero additional latency.
- Output values during reset and cycle 1 after release:
  - digit=0, segments=0111111 (inverted if COMMON_ANODE), dp=0 (1 if COMMON_ANODE)
  - tick=0, wrap=0, pre_cnt=0
- First tick after reset release with run=1: cycle `limit` (cnt reaches limit−1 on cycle limit−1, counting from 0).
- clear or load asserted for N cycles holds the block at its cleared/loaded value. The step period restarts on the first cycle without clear or load.

## Test plan
- **Basic up count.** PRESCALE=8, DIGIT_MAX=9, speed=0, run=1, up_dn=1 from reset. Required: tick every 8 cycles; digit 0→1→…→9→0; wrap=1 only on the 9→0 tick; dp toggles each tick.
- **Down count and speed.** PRESCALE=8, up_dn=0, speed=2, from reset. Required: tick every 2 cycles; digit 0→9 with wrap on the first tick, then 9→8→7.
- **Speed change mid-count.** Speed 0, let cnt reach 5, then set speed=3 (limit 1). Required: tick on the next cycle, cnt=0 afterwards, then a tick every cycle.
- **Load and clamp.** load=1, load_val=13, DIGIT_MAX=9. Required: digit=9 next cycle, cnt=0, segments=1101111. Load coinciding with a tick cycle: tick=0 and no step.
- **Hold and clear.** run=0 for 20 cycles mid-count. Required: digit, dp and cnt frozen; tick=0. Then clear together with load: digit=0, cnt=0, dp=0, because clear has priority.
- **Hex decode and polarity.** DIGIT_MAX=15, COMMON_ANODE=1, load each value 0..15. Required: segments equal the bitwise inverse of the table, e.g. A → 0001000. Also assert rst_n=0 mid-count: all outputs at reset values on the next edge.
